// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int REQ_WIDTH  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          gnt_valid,
  output logic [REQ_WIDTH-1:0]          gnt_id,
  output logic                          wen,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          w_full
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [REQ_WIDTH:0]   NUM_REQ_X = (REQ_WIDTH + 1)'(NUM_REQ);
  localparam logic [REQ_WIDTH-1:0] LAST_ID   = REQ_WIDTH'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);

  state_e                 state_q, state_d;
  logic [REQ_WIDTH-1:0]   gnt_id_q, gnt_id_d;
  logic [REQ_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;

  logic [DATA_WIDTH-1:0]  data_arr [NUM_REQ];
  logic [REQ_WIDTH:0]     idx;
  logic [REQ_WIDTH-1:0]   winner;
  logic [REQ_WIDTH-1:0]   next_ptr;
  logic                   any_req;
  logic                   req_held;
  logic                   burst_done;
  logic                   advance_rr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First set request at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    idx     = '0;
    winner  = rr_ptr_q;
    any_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (REQ_WIDTH + 1)'(i);
      if (idx >= NUM_REQ_X) idx = idx - NUM_REQ_X;
      if (!any_req && req[idx[REQ_WIDTH-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[REQ_WIDTH-1:0];
      end
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (req[0]) begin
      any_req = 1'b1;
      winner  = '0;
    end
`endif
  end

`ifdef FIFO_ARB_PRIO0_EN
  // Priority grants to requester 0 leave the round-robin position untouched.
  assign advance_rr = (gnt_id_q != '0);
`else
  assign advance_rr = 1'b1;
`endif

  assign next_ptr   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + REQ_WIDTH'(1);
  assign req_held   = req[gnt_id_q];
  assign burst_done = (burst_cnt_q == LAST_BEAT);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    ack         = '0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_id_d    = winner;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        // A dropped request ends the burst before any beat is considered.
        if (!req_held) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
          if (advance_rr) rr_ptr_d = next_ptr;
        end else if (!w_full) begin
          ack[gnt_id_q] = 1'b1;
          if (burst_done) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
            if (advance_rr) rr_ptr_d = next_ptr;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q     <= IDLE;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign gnt_valid = (state_q == GRANT);
  assign gnt_id    = gnt_id_q;
  assign wen       = |ack;
  assign wdata     = data_arr[gnt_id_q];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed bench with a write scoreboard for fifo_wr_arbiter.
// Tests the FIFO_ARB_PRIO0_EN variant when that macro is defined.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        gnt_valid;
  logic [1:0]  gnt_id;
  logic        wen;
  logic [7:0]  wdata;
  logic        w_full;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  int    checks    = 0;
  int    passed    = 0;
  int    failed    = 0;
  int    wen_count = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .REQ_WIDTH(2), .DATA_WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(4)
  ) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .ack(ack),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .wen(wen), .wdata(wdata), .w_full(w_full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_beats(input logic [1:0] id, input logic [7:0] data, input int n);
    beat_t b;
    b.id   = id;
    b.data = data;
    repeat (n) sb.push_back(b);
  endtask

  // Sample the current cycle mid-period, retire any write against the scoreboard, advance one edge.
  task automatic run_cycle();
    beat_t exp_b;
    @(negedge wclk);
    check("wen_is_or_ack", wen, |ack);
    if (w_full) check("wen_while_full", wen, 0);
    if (wen) begin
      wen_count++;
      check("write_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        check("write_id", gnt_id, exp_b.id);
        check("write_data", wdata, exp_b.data);
        check("write_ack", ack, 4'b0001 << exp_b.id);
      end
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic expect_no_beat(input string tag, input logic [1:0] id);
    @(negedge wclk);
    check({tag, "_wen"}, wen, 0);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_gnt_valid"}, gnt_valid, 1);
    check({tag, "_gnt_id"}, gnt_id, id);
    @(posedge wclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset held for two edges with every request asserted.
    wrst     = 1'b1;
    req      = 4'b1111;
    req_data = {8'h40, 8'h30, 8'h20, 8'h10};
    w_full   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge wclk);
      #1;
      @(negedge wclk);
      check("rst_gnt_valid", gnt_valid, 0);
      check("rst_wen", wen, 0);
      check("rst_ack", ack, 0);
      check("rst_gnt_id", gnt_id, 0);
    end
    wrst = 1'b0;
`ifndef FIFO_ARB_PRIO0_EN
    // Test 2: all requesters active, grant order 0,1,2,3,0 with 4 beats each.
    expect_beats(2'd0, 8'h10, 4);
    expect_beats(2'd1, 8'h20, 4);
    expect_beats(2'd2, 8'h30, 4);
    expect_beats(2'd3, 8'h40, 4);
    expect_beats(2'd0, 8'h10, 4);
`else
    expect_beats(2'd0, 8'h10, 4);
`endif
    @(posedge wclk);
    #1;
    check("first_grant_valid", gnt_valid, 1);
    check("first_grant_id", gnt_id, 0);
    wen_count = 0;
`ifndef FIFO_ARB_PRIO0_EN
    for (int i = 0; i < 24; i++) run_cycle();
    check("t2_writes_in_25", wen_count, 20);
`else
    for (int i = 0; i < 4; i++) run_cycle();
`endif
    req = 4'b0000;
    check("t2_idle_after", gnt_valid, 0);
    run_cycle();
    check("t2_sb_drained", sb.size(), 0);

`ifndef FIFO_ARB_PRIO0_EN
    // Test 3: requester 2 alone, FIFO full for 3 cycles after the 2nd beat.
    req               = 4'b0100;
    req_data[23:16]   = 8'h5A;
    expect_beats(2'd2, 8'h5A, 4);
    run_cycle();
    check("t3_gnt_id", gnt_id, 2);
    check("t3_gnt_valid", gnt_valid, 1);
    run_cycle();
    run_cycle();
    w_full = 1'b1;
    for (int i = 0; i < 3; i++) expect_no_beat("t3_stall", 2'd2);
    w_full = 1'b0;
    run_cycle();
    run_cycle();
    req = 4'b0000;
    check("t3_idle_after", gnt_valid, 0);
    run_cycle();
    check("t3_sb_drained", sb.size(), 0);

    // Test 4: requester 1 drops after 2 beats; requester 3 is next.
    req             = 4'b0010;
    req_data[15:8]  = 8'hC3;
    req_data[31:24] = 8'h7E;
    expect_beats(2'd1, 8'hC3, 2);
    run_cycle();
    check("t4_gnt_id", gnt_id, 1);
    run_cycle();
    req = 4'b1010;
    run_cycle();
    req = 4'b1000;
    expect_no_beat("t4_drop", 2'd1);
    check("t4_idle_after_drop", gnt_valid, 0);
    expect_beats(2'd3, 8'h7E, 4);
    run_cycle();
    check("t4_next_gnt_id", gnt_id, 3);
    for (int i = 0; i < 4; i++) run_cycle();
    req = 4'b0000;
    check("t4_idle_after", gnt_valid, 0);
    run_cycle();
    check("t4_sb_drained", sb.size(), 0);

    // Test 5: move rr_ptr to 3, then requesters 3 and 0 show the 3 -> 0 wrap.
    req = 4'b0100;
    expect_beats(2'd2, 8'h5A, 1);
    run_cycle();
    run_cycle();
    req = 4'b0000;
    expect_no_beat("t5_drop", 2'd2);
    req            = 4'b1001;
    req_data[7:0]  = 8'hE1;
    expect_beats(2'd3, 8'h7E, 4);
    expect_beats(2'd0, 8'hE1, 4);
    run_cycle();
    check("t5_first_gnt_id", gnt_id, 3);
    for (int i = 0; i < 4; i++) run_cycle();
    check("t5_idle_between", gnt_valid, 0);
    run_cycle();
    check("t5_wrap_gnt_id", gnt_id, 0);
    for (int i = 0; i < 4; i++) run_cycle();
    req = 4'b0000;
    check("t5_idle_after", gnt_valid, 0);
    run_cycle();
    check("t5_sb_drained", sb.size(), 0);
`else
    // Test 6: requester 0 rises during requester 1's burst; 1 finishes, then 0, then 2.
    req             = 4'b1110;
    req_data[15:8]  = 8'hC3;
    req_data[23:16] = 8'h5A;
    expect_beats(2'd1, 8'hC3, 4);
    run_cycle();
    check("t6_gnt_id_1", gnt_id, 1);
    run_cycle();
    req = 4'b1111;
    expect_beats(2'd0, 8'h10, 4);
    run_cycle();
    run_cycle();
    run_cycle();
    check("t6_idle_after_1", gnt_valid, 0);
    run_cycle();
    check("t6_gnt_id_0", gnt_id, 0);
    for (int i = 0; i < 4; i++) run_cycle();
    check("t6_idle_after_0", gnt_valid, 0);
    run_cycle();
    check("t6_gnt_id_2", gnt_id, 2);
    req = 4'b0000;
    expect_no_beat("t6_drop", 2'd2);
    check("t6_sb_drained", sb.size(), 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
